// File: rtl/dma_mem_if.sv
// dma_mem_if: read/write request and response signals between a DMA master
// and the dma_mem_model memory responder.
//   Write channel: axi_waddr_i, axi_wdata_i, axi_wsel_i, axi_wvalid_i,
//                  axi_wlen_i, axi_wfixed_i (master -> memory)
//                  axi_werr_o, axi_wrdy_o (memory -> master)
//   Read channel:  axi_raddr_i, axi_rvalid_i, axi_rsel_i, axi_rlen_i,
//                  axi_rfixed_i (master -> memory)
//                  axi_rdata_o, axi_rrdy_o, axi_rerr_o (memory -> master)
// The _i/_o suffixes are from the memory's point of view.
interface dma_mem_if;
  logic [31:0] axi_waddr_i;
  logic [63:0] axi_wdata_i;
  logic [7:0]  axi_wsel_i;
  logic        axi_wvalid_i;
  logic [3:0]  axi_wlen_i;
  logic        axi_wfixed_i;
  logic        axi_werr_o;
  logic        axi_wrdy_o;

  logic [31:0] axi_raddr_i;
  logic        axi_rvalid_i;
  logic [7:0]  axi_rsel_i;
  logic [3:0]  axi_rlen_i;
  logic        axi_rfixed_i;
  logic [63:0] axi_rdata_o;
  logic        axi_rrdy_o;
  logic        axi_rerr_o;

  modport master (
    output axi_waddr_i, axi_wdata_i, axi_wsel_i, axi_wvalid_i, axi_wlen_i, axi_wfixed_i,
    input  axi_werr_o, axi_wrdy_o,
    output axi_raddr_i, axi_rvalid_i, axi_rsel_i, axi_rlen_i, axi_rfixed_i,
    input  axi_rdata_o, axi_rrdy_o, axi_rerr_o
  );

  modport slave (
    input  axi_waddr_i, axi_wdata_i, axi_wsel_i, axi_wvalid_i, axi_wlen_i, axi_wfixed_i,
    output axi_werr_o, axi_wrdy_o,
    input  axi_raddr_i, axi_rvalid_i, axi_rsel_i, axi_rlen_i, axi_rfixed_i,
    output axi_rdata_o, axi_rrdy_o, axi_rerr_o
  );
endinterface

// File: rtl/dma_mem_model.sv
// dma_mem_model: DEPTH_WORDS x 64-bit memory mapped at BASE_ADDR, serving
// incremental and fixed read/write bursts with programmable wait states and
// byte selects. Bad requests (misaligned, below base, running past the end)
// are rejected as a whole and flagged on axi_rerr_o / axi_werr_o until the
// master drops its valid.
// Ports:
//   axi_clk_i  clock
//   axi_rst_i  synchronous active-high reset (memory contents are kept)
//   bus        dma_mem_if.slave, read and write channels
module dma_mem_model #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH_WORDS = 16,
  parameter int          RD_LATENCY  = 1,
  parameter int          WR_LATENCY  = 1
) (
  input  logic      axi_clk_i,
  input  logic      axi_rst_i,
  dma_mem_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_WAIT = 3'd1;
  localparam logic [2:0] R_DATA = 3'd2;
  localparam logic [2:0] R_HOLD = 3'd3;
  localparam logic [2:0] R_ERR  = 3'd4;

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_WAIT = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_HOLD = 3'd3;
  localparam logic [2:0] W_ERR  = 3'd4;

  localparam logic [63:0] ERR_DATA    = 64'hdeaddead_deaddead;
  localparam logic [3:0]  RD_CNT_INIT = 4'(RD_LATENCY - 1);
  localparam logic [3:0]  WR_CNT_INIT = 4'(WR_LATENCY - 1);

  // Zero at time zero only; reset deliberately leaves the contents alone.
  logic [63:0] mem [DEPTH_WORDS] = '{default: '0};

  function automatic logic [63:0] byte_mask(input logic [7:0] sel);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[k*8 +: 8] = {8{sel[k]}};
    return m;
  endfunction

  // The whole burst is checked up front, so the index never leaves the array.
  function automatic logic req_error(input logic [31:0] addr, input logic [3:0] len,
                                     input logic fixed);
    logic [31:0] last;
    last = ((addr - BASE_ADDR) >> 3) + (fixed ? 32'd0 : 32'(len));
    return (addr[2:0] != 3'd0) || (addr < BASE_ADDR) || (last >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  // ---------------- read FSM ----------------
  logic [2:0]       r_state;
  logic [3:0]       r_cnt;
  logic [3:0]       r_beat;
  logic [3:0]       r_len;
  logic             r_fixed;
  logic [7:0]       r_sel;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_data;
  logic             r_rdy;
  logic             r_err;

  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.axi_rvalid_i) begin
            r_sel   <= bus.axi_rsel_i;
            r_len   <= bus.axi_rlen_i;
            r_fixed <= bus.axi_rfixed_i;
            r_idx   <= word_index(bus.axi_raddr_i);
            if (req_error(bus.axi_raddr_i, bus.axi_rlen_i, bus.axi_rfixed_i)) begin
              r_state <= R_ERR;
              r_err   <= 1'b1;
              r_data  <= ERR_DATA;
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= RD_CNT_INIT;
            end
          end
        end
        R_WAIT: begin
          // The first beat is registered on the way into R_DATA so rrdy
          // lines up with the RD_LATENCY+1 cycle request-to-data latency.
          if (r_cnt == 4'd0) begin
            r_state <= R_DATA;
            r_rdy   <= 1'b1;
            r_data  <= mem[r_idx] & byte_mask(r_sel);
            r_beat  <= '0;
            if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          // Beat r_beat is on the bus now; either present the next or stop.
          if (r_beat == r_len) begin
            r_state <= R_HOLD;
            r_rdy   <= 1'b0;
            r_data  <= '0;
          end else begin
            r_data <= mem[r_idx] & byte_mask(r_sel);
            r_beat <= r_beat + 4'd1;
            if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
          end
        end
        R_HOLD: begin
          if (!bus.axi_rvalid_i) r_state <= R_IDLE;
        end
        R_ERR: begin
          if (!bus.axi_rvalid_i) begin
            r_state <= R_IDLE;
            r_err   <= 1'b0;
            r_data  <= '0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.axi_rdata_o = r_data;
  assign bus.axi_rrdy_o  = r_rdy;
  assign bus.axi_rerr_o  = r_err;

  // ---------------- write FSM ----------------
  logic [2:0]       w_state;
  logic [3:0]       w_cnt;
  logic [3:0]       w_beat;
  logic [3:0]       w_len;
  logic             w_fixed;
  logic [IDX_W-1:0] w_idx;
  logic             w_rdy;
  logic             w_err;
  logic             mem_we;

  // wrdy is held high throughout W_DATA, so a beat lands whenever wvalid is up.
  assign mem_we = (w_state == W_DATA) && bus.axi_wvalid_i && !axi_rst_i;

  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_beat  <= '0;
      w_rdy   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.axi_wvalid_i) begin
            w_len   <= bus.axi_wlen_i;
            w_fixed <= bus.axi_wfixed_i;
            w_idx   <= word_index(bus.axi_waddr_i);
            if (req_error(bus.axi_waddr_i, bus.axi_wlen_i, bus.axi_wfixed_i)) begin
              w_state <= W_ERR;
              w_err   <= 1'b1;
            end else begin
              w_state <= W_WAIT;
              w_cnt   <= WR_CNT_INIT;
            end
          end
        end
        W_WAIT: begin
          if (w_cnt == 4'd0) begin
            w_state <= W_DATA;
            w_rdy   <= 1'b1;
            w_beat  <= '0;
          end else begin
            w_cnt <= w_cnt - 4'd1;
          end
        end
        W_DATA: begin
          if (bus.axi_wvalid_i) begin
            if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
            if (w_beat == w_len) begin
              w_state <= W_HOLD;
              w_rdy   <= 1'b0;
            end else begin
              w_beat <= w_beat + 4'd1;
            end
          end
        end
        W_HOLD: begin
          if (!bus.axi_wvalid_i) w_state <= W_IDLE;
        end
        W_ERR: begin
          if (!bus.axi_wvalid_i) begin
            w_state <= W_IDLE;
            w_err   <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Non-blocking update: a read of the same word in this cycle sees the old value.
  always_ff @(posedge axi_clk_i) begin
    if (mem_we) begin
      mem[w_idx] <= (mem[w_idx] & ~byte_mask(bus.axi_wsel_i)) |
                    (bus.axi_wdata_i & byte_mask(bus.axi_wsel_i));
    end
  end

  assign bus.axi_wrdy_o = w_rdy;
  assign bus.axi_werr_o = w_err;

endmodule

// File: doc/dma_mem_model.md
Name: dma_mem_model

Overview:
- Parametrised 64-bit AXI-client memory model for DMA testbenches. It replaces the fixed-content, single-beat read responder.
- Holds a DEPTH_WORDS x 64-bit array mapped at BASE_ADDR.
- Serves read and write bursts, both incremental and fixed, with programmable wait states and byte selects.
- Reports range and alignment errors and recovers from them instead of trapping.

Parameters:
BASE_ADDR, 32'h10000000, byte address of word 0; must be 8-byte aligned
DEPTH_WORDS, 16, number of 64-bit words; 1..4096
RD_LATENCY, 1, cycles from read request acceptance to first data beat; 1..15
WR_LATENCY, 1, cycles from write request acceptance to first wrdy; 1..15

Ports:
axi_clk_i  in  1  clock
axi_rst_i  in  1  reset, synchronous, active-high
axi_waddr_i  in  32  write start address
axi_wdata_i  in  64  write data
axi_wsel_i  in  8  write byte enables
axi_wvalid_i  in  1  write request/data valid
axi_wlen_i  in  4  write burst length; beats = wlen+1
axi_wfixed_i  in  1  1 = fixed address burst, 0 = incremental
axi_werr_o  out  1  write error
axi_wrdy_o  out  1  write beat accepted
axi_raddr_i  in  32  read start address
axi_rvalid_i  in  1  read request valid
axi_rsel_i  in  8  read byte enables
axi_rlen_i  in  4  read burst length; beats = rlen+1
axi_rfixed_i  in  1  1 = fixed address burst, 0 = incremental
axi_rdata_o  out  64  read data
axi_rrdy_o  out  1  read data beat valid
axi_rerr_o  out  1  read error

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: all outputs 0; both FSMs go to IDLE; beat counters clear. Memory is NOT cleared (init 0 at time zero only). Reset mid-burst aborts the burst; remaining beats are discarded.
- Read and write FSMs are independent and may run concurrently.
- Request check at acceptance, for both directions:
  - error if addr[2:0] != 0,
  - or addr < BASE_ADDR,
  - or last word index >= DEPTH_WORDS.
  - Last word index = (addr-BASE_ADDR)/8 + len for incremental bursts; (addr-BASE_ADDR)/8 for fixed bursts.
  - The whole burst is rejected; a burst never partially transfers.
- Read FSM states: R_IDLE, R_WAIT, R_DATA, R_HOLD, R_ERR.
  - R_IDLE: on rvalid, latch addr, rsel, rlen, rfixed. Error -> R_ERR. Otherwise -> R_WAIT with counter = RD_LATENCY-1.
  - R_WAIT: decrement the counter; at 0 -> R_DATA.
  - R_DATA: rrdy=1 for rlen+1 consecutive cycles, one beat per cycle.
    - rdata byte k = mem[idx] byte k if rsel[k], else 8'h00.
    - idx increments each beat unless fixed.
    - After the last beat, rrdy=0 and go to R_HOLD.
  - R_HOLD: wait for rvalid=0 -> R_IDLE. Requests held high are not re-served.
  - R_ERR: rerr=1, rdata=64'hdeaddead_deaddead, rrdy=0. When rvalid=0: rerr=0 and -> R_IDLE.
  - If rvalid drops during R_WAIT or R_DATA, the burst continues to completion. The master must ignore the extra beats.
  - Total latency: first rrdy appears RD_LATENCY+1 cycles after the cycle rvalid is first sampled high.
- Write FSM states: W_IDLE, W_WAIT, W_DATA, W_HOLD, W_ERR.
  - W_IDLE: on wvalid, latch addr, wlen, wfixed. Error -> W_ERR. Otherwise -> W_WAIT with counter = WR_LATENCY-1.
  - W_WAIT: count down as for reads; at 0 -> W_DATA.
  - W_DATA: wrdy=1. A beat is accepted on a cycle with wvalid=1 and wrdy=1.
    - Accepted beat writes byte k of mem[idx] where wsel[k]=1.
    - idx advances unless fixed.
    - wvalid=0 stalls the burst with wrdy held at 1.
    - After beat wlen+1: wrdy=0 and -> W_HOLD.
  - W_HOLD: wait for wvalid=0 -> W_IDLE.
  - W_ERR: werr=1, no writes. When wvalid=0: werr=0 and -> W_IDLE.
- Same-word read and write in the same cycle: the read returns the old value; the new value is visible from the next cycle.
- Index arithmetic is 32-bit unsigned; no wrap-around inside the array, since out-of-range bursts are rejected up front.
- Simulation-only model; no synthesis constraint.

Test Plan:
1. Incremental write burst: reset, then write addr 32'h10000000, wlen=3, wsel=8'hFF, data 1,2,3,4 -> 4 wrdy cycles starting WR_LATENCY+1 cycles after request. A follow-up read of the same address with rlen=3, rsel=8'hFF returns 1,2,3,4 on 4 consecutive rrdy cycles, first one RD_LATENCY+1 cycles after request.
2. Byte-select write: word 5 holds 64'h11223344_55667788; write wsel=8'h0F, data 64'hAAAAAAAA_BBBBBBBB at 32'h10000028 -> read returns 64'h11223344_BBBBBBBB. A read of the same word with rsel=8'hF0 returns 64'h11223344_00000000.
3. Fixed burst: write 32'h10000010, wlen=2, wfixed=1, data A,B,C -> only word 2 changes and ends as C. A fixed read with rlen=2 returns C,C,C.
4. Range error: read 32'h10000070, rlen=3, DEPTH_WORDS=16 (last index 17) -> rerr=1, rrdy never asserts, rdata=deaddead_deaddead. Drop rvalid -> rerr=0, and the next valid read succeeds.
5. Alignment error: write 32'h10000004 -> werr=1, memory unchanged, recovery on wvalid=0.
6. Reset mid-read: assert axi_rst_i during the 2nd beat of a 4-beat read -> next cycle rrdy=0 and rdata=0; memory contents intact on the next read. Also: a write stalled by wvalid=0 for 3 cycles completes correctly.
